// File: rtl/uart_tx_param.sv
// uart_tx_param
//   Parametrised UART transmitter. One word is taken per valid/ready
//   handshake and sent as: start bit, DATA_BITS data bits LSB first,
//   optional parity bit, STOP_BITS stop bits. Each bit lasts CLK_DIV clocks.
//
// Parameters
//   CLK_DIV   clocks per bit (>= 2)
//   DATA_BITS data bits per frame (5..9)
//   PARITY    0 = none, 1 = odd, 2 = even
//   STOP_BITS 1 or 2
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   tx_data   word to send, captured on the accept edge only
//   tx_valid  source has a word
//   tx_ready  block can accept (high only while idle)
//   tx        serial line, idles high
//   tx_busy   high from accept until frame end
//   done      one-cycle pulse when a frame completes
module uart_tx_param #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 done
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);
  localparam logic          SMAX = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state,    w_state;
  logic [TW-1:0]         r_timer,    w_timer;
  logic [BW-1:0]         r_bit_cnt,  w_bit_cnt;
  logic                  r_stop_cnt, w_stop_cnt;
  logic [DATA_BITS-1:0]  r_shift,    w_shift;
  logic                  r_par,      w_par;
  logic                  r_tx,       w_tx;
  logic                  r_ready,    w_ready;
  logic                  r_busy,     w_busy;
  logic                  r_done,     w_done;
  logic                  w_tick;

  assign w_tick = (r_timer == TMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_timer    <= w_timer;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_shift    <= w_shift;
      r_par      <= w_par;
      r_tx       <= w_tx;
      r_ready    <= w_ready;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  // Outputs are registered: the line value for the next bit is chosen here
  // from the next state, so tx changes on the same edge the state does.
  always_comb begin
    w_state    = r_state;
    w_timer    = r_timer;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_shift    = r_shift;
    w_par      = r_par;
    w_tx       = r_tx;
    w_done     = 1'b0;

    if (r_state != S_IDLE) begin
      w_timer = w_tick ? '0 : r_timer + TW'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_tx = 1'b1;
        if (tx_valid && r_ready) begin
          w_state = S_START;
          w_shift = tx_data;
          // Parity is taken from the captured word, so later tx_data
          // changes cannot disturb it.
          w_par   = (PARITY == 1) ? ~^tx_data : ^tx_data;
          w_timer = '0;
          w_tx    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state   = S_DATA;
          w_bit_cnt = '0;
          w_tx      = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BMAX) begin
            if (PARITY != 0) begin
              w_state = S_PARITY;
              w_tx    = r_par;
            end else begin
              w_state    = S_STOP;
              w_stop_cnt = 1'b0;
              w_tx       = 1'b1;
            end
          end else begin
            w_shift   = r_shift >> 1;
            w_bit_cnt = r_bit_cnt + BW'(1);
            w_tx      = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state    = S_STOP;
          w_stop_cnt = 1'b0;
          w_tx       = 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_stop_cnt == SMAX) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
            w_tx    = 1'b1;
          end else begin
            w_stop_cnt = 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
      end
    endcase

    w_ready = (w_state == S_IDLE);
    w_busy  = (w_state != S_IDLE);
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
//   Four transmitter instances with different frame formats share one clock:
//     0: CLK_DIV=16, 8N1 (defaults)
//     1: CLK_DIV=4, 8 data, odd parity, 1 stop
//     2: CLK_DIV=4, 8N1
//     3: CLK_DIV=4, 5 data, even parity, 2 stops
//   Each sampled clock compares {tx, tx_ready, tx_busy, done} against the
//   hand-written bit sequence of the frame.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rstn [4];
  logic       v    [4];
  logic [7:0] d    [3];
  logic [4:0] d3;
  logic       txo  [4];
  logic       rdy  [4];
  logic       busy [4];
  logic       dn   [4];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_param u0 (
    .clk(clk), .rst_n(rstn[0]), .tx_data(d[0]), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .tx_busy(busy[0]), .done(dn[0])
  );
  uart_tx_param #(.CLK_DIV(4), .PARITY(1)) u1 (
    .clk(clk), .rst_n(rstn[1]), .tx_data(d[1]), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .tx_busy(busy[1]), .done(dn[1])
  );
  uart_tx_param #(.CLK_DIV(4)) u2 (
    .clk(clk), .rst_n(rstn[2]), .tx_data(d[2]), .tx_valid(v[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .tx_busy(busy[2]), .done(dn[2])
  );
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(2), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rstn[3]), .tx_data(d3), .tx_valid(v[3]),
    .tx_ready(rdy[3]), .tx(txo[3]), .tx_busy(busy[3]), .done(dn[3])
  );

  // bits: line values written left to right as they appear on the wire,
  // right-aligned in the vector; nbits of them are used.
  typedef struct {
    logic [1:0]  dut;
    logic [7:0]  data;
    logic [15:0] bits;
    int          nbits;
    int          cd;
    bit          stray;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [3:0] outs(input logic [1:0] dut);
    return {txo[dut], rdy[dut], busy[dut], dn[dut]};
  endfunction

  function automatic logic wire_bit(input logic [15:0] bits, input int nbits, input int idx);
    return bits[nbits-1-idx];
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: {tx,rdy,busy,done} got %b expected %b", name, act, exp);
  endtask

  task automatic set_in(input logic [1:0] dut, input logic val, input logic [7:0] data);
    v[dut] = val;
    if (dut == 2'd3) d3 = data[4:0];
    else d[dut] = data;
  endtask

  // Called away from a clock edge; the next rising edge is the accept edge.
  task automatic run_frame(input vec_t vv, input string tag);
    int n;
    logic [3:0] exp;
    n = vv.nbits * vv.cd;
    set_in(vv.dut, 1'b1, vv.data);
    @(posedge clk); #1;
    v[vv.dut] = 1'b0;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      exp = (c < n) ? {wire_bit(vv.bits, vv.nbits, c / vv.cd), 3'b010} : 4'b1101;
      chk($sformatf("%s clk%0d", tag, c), outs(vv.dut), exp);
      if (vv.stray) begin
        if (c == 2 * vv.cd + 1) set_in(vv.dut, 1'b1, 8'hFF);
        if (c == 2 * vv.cd + 2) v[vv.dut] = 1'b0;
        if (c == 5 * vv.cd)     set_in(vv.dut, 1'b0, 8'h00);
      end
    end
    @(posedge clk); #1;
    chk($sformatf("%s after_done", tag), outs(vv.dut), 4'b1100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ba;
    logic [15:0] bc;
    logic [3:0]  exp;

    vecs[0] = '{dut: 2'd0, data: 8'hAA, bits: 16'b0010101011,  nbits: 10, cd: 16, stray: 1'b0};
    vecs[1] = '{dut: 2'd1, data: 8'h07, bits: 16'b01110000001, nbits: 11, cd: 4,  stray: 1'b0};
    vecs[2] = '{dut: 2'd1, data: 8'h03, bits: 16'b01100000011, nbits: 11, cd: 4,  stray: 1'b0};
    vecs[3] = '{dut: 2'd3, data: 8'h15, bits: 16'b010101111,   nbits: 9,  cd: 4,  stray: 1'b0};
    vecs[4] = '{dut: 2'd2, data: 8'h3C, bits: 16'b0001111001,  nbits: 10, cd: 4,  stray: 1'b1};
    vecs[5] = '{dut: 2'd2, data: 8'h5A, bits: 16'b0010110101,  nbits: 10, cd: 4,  stray: 1'b0};

    for (int i = 0; i < 4; i++) begin
      rstn[i] = 1'b0;
      v[i]    = 1'b0;
    end
    for (int i = 0; i < 3; i++) d[i] = 8'h00;
    d3 = 5'h00;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("reset u%0d", i), outs(2'(i)), 4'b1100);
    for (int i = 0; i < 4; i++) rstn[i] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("idle u%0d", i), outs(2'(i)), 4'b1100);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back on u2: valid held, 0xAA then 0xCC.
    ba = 16'b0010101011;
    bc = 16'b0001100111;
    set_in(2'd2, 1'b1, 8'hAA);
    @(posedge clk); #1;
    for (int c = 0; c <= 82; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c == 1) d[2] = 8'hCC;
      if (c < 40)       exp = {wire_bit(ba, 10, c / 4), 3'b010};
      else if (c == 40) exp = 4'b1101;
      else if (c < 81)  exp = {wire_bit(bc, 10, (c - 41) / 4), 3'b010};
      else if (c == 81) exp = 4'b1101;
      else              exp = 4'b1100;
      if (c == 41) v[2] = 1'b0;
      chk($sformatf("b2b clk%0d", c), outs(2'd2), exp);
    end

    // Reset during data bit 3 of 0xF0 on u2 (data bit 3 covers clocks 16..19).
    set_in(2'd2, 1'b1, 8'hF0);
    @(posedge clk); #1;
    v[2] = 1'b0;
    chk("rst accept", outs(2'd2), 4'b0010);
    repeat (16) @(posedge clk);
    #1;
    chk("rst bit3", outs(2'd2), 4'b0010);
    rstn[2] = 1'b0;
    @(posedge clk); #1;
    chk("rst abort", outs(2'd2), 4'b1100);
    // Valid held during reset must not be accepted until rst_n returns high.
    set_in(2'd2, 1'b1, 8'h5A);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst hold%0d", c), outs(2'd2), 4'b1100);
    end
    rstn[2] = 1'b1;
    run_frame(vecs[5], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
